spi_target_regs: RTL and testbench
==================================

SPI_TARGET_REGS -- requirements
Module: spi_target_regs

Interface
REQ-001 Parameter ADDR_W, default 7, register address width (command byte bits 6:0).
REQ-002 Parameter SCK_DIV_MIN, default 8, minimum supported clk cycles per SCK period; documentation only, no logic.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 spii_sck  in  1  SPI clock from the controller in master mode; asynchronous, mode 0 (CPOL=0, CPHA=0).
REQ-006 spii_mosi  in  1  serial data in, MSB first; asynchronous.
REQ-007 spii_spisel  in  1  target select, active low; asynchronous.
REQ-008 spio_miso  out  1  serial data out, MSB first.
REQ-009 spio_misooen  out  1  MISO output enable, active low (0 = drive).
REQ-010 reg_addr  out  ADDR_W  local register address.
REQ-011 reg_we  out  1  one-cycle write strobe.
REQ-012 reg_wdata  out  8  write data, valid with reg_we.
REQ-013 reg_re  out  1  one-cycle read strobe.
REQ-014 reg_rdata  in  8  read data, valid the cycle after reg_re.
REQ-015 busy  out  1  high while a frame is active (select low).

Function
REQ-016 sck, mosi and spisel SHALL each pass through a 2-FF synchronizer; sck rise/fall SHALL be detected from the synchronized samples as 1-cycle pulses.
REQ-017 mosi SHALL be sampled on sck rise; miso SHALL change only on sck fall or on a read-data load.
REQ-018 FSM states: IDLE, CMD, WR_DATA, RD_DATA; encoding from the package.
REQ-019 IDLE -> CMD when synchronized spisel goes low; bit counter cleared.
REQ-020 In CMD, after 8 bits: bit 7 = 1 -> RD_DATA, 0 -> WR_DATA; reg_addr <= bits 6:0.
REQ-021 On entering RD_DATA, reg_re SHALL pulse in the same cycle as the 8th rise; on the next cycle reg_rdata SHALL be loaded into the TX shifter and its bit 7 driven on spio_miso.
REQ-022 In RD_DATA, after each 8th rise, reg_addr SHALL increment, reg_re SHALL pulse and the TX shifter reload as in REQ-021.
REQ-023 In WR_DATA, after each 8th rise, reg_we SHALL pulse for exactly one cycle with reg_wdata = received byte and the current reg_addr; reg_addr increments the following cycle.
REQ-024 reg_addr increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-025 spio_misooen SHALL be 0 only in RD_DATA while select is low; otherwise 1, with spio_miso = 0.
REQ-026 spisel rising in any state SHALL return to IDLE the next cycle; a partial byte SHALL be discarded with no reg_we.
REQ-027 Deselect coincident with an 8th rise: the completed byte SHALL still produce its reg_we/reg_re, then return to IDLE.
REQ-028 sck edges while spisel is high SHALL be ignored.
REQ-029 busy = synchronized spisel low.
REQ-030 Total latency from the pin-level 8th sck rise to reg_we SHALL be 3 clk cycles (2 sync + 1 detect).

Reset
REQ-031 While rst is high: state = IDLE, counters/shifters = 0, reg_addr = 0, reg_we = reg_re = 0, reg_wdata = 0, spio_miso = 0, spio_misooen = 1, busy = 0, synchronizers loaded with idle levels (sck 0, spisel 1).
REQ-032 Reset mid-frame SHALL abort without any strobe; after release, the FSM SHALL wait for a fresh spisel falling edge.

Structure
REQ-033 Package spi_target_pkg SHALL hold the state enum, CMD_RW_BIT = 7 and the byte width constant 8.
REQ-034 One sub-module spi_target_sync SHALL contain the 2-FF synchronizer plus rise/fall detection, instantiated for sck and spisel, and for mosi without edge outputs.

Verification
REQ-035 Write frame 0x05, 0xA5, 0x3C with SCK = clk/8 -> reg_we twice: (addr 0x05, 0xA5), (addr 0x06, 0x3C); no reg_re.
REQ-036 Read frame 0x90, two dummy bytes, model returns 0x11 @0x10 and 0x22 @0x11 -> MISO bytes 0x11, 0x22; misooen low only during the data bytes.
REQ-037 Write at 0x7F with two data bytes -> second reg_we at addr 0x00.
REQ-038 Deselect after 5 bits of the first write data byte -> no reg_we, state IDLE; next frame decodes normally.
REQ-039 rst asserted during the 3rd bit of a read data byte -> all outputs at reset values the next cycle; no strobes until a new select.
REQ-040 sck toggled 16 times with spisel high -> no strobes, busy = 0, misooen = 1.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared constants and FSM state encoding for the SPI register target.
package spi_target_pkg;

  localparam int BYTE_W     = 8;
  localparam int CMD_RW_BIT = 7;
  localparam int BIT_CNT_W  = $clog2(BYTE_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_t;

endpackage

// File: rtl/spi_target_regs_if.sv
// SPI pins plus local register bus of the SPI register target.
// slave: the target itself; master: the controller / register-file side.
interface spi_target_regs_if #(
  parameter int ADDR_W = 7
);
  import spi_target_pkg::*;

  logic              spii_sck;
  logic              spii_mosi;
  logic              spii_spisel;
  logic              spio_miso;
  logic              spio_misooen;
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_we;
  logic [BYTE_W-1:0] reg_wdata;
  logic              reg_re;
  logic [BYTE_W-1:0] reg_rdata;
  logic              busy;

  modport slave (
    input  spii_sck,
    input  spii_mosi,
    input  spii_spisel,
    input  reg_rdata,
    output spio_miso,
    output spio_misooen,
    output reg_addr,
    output reg_we,
    output reg_wdata,
    output reg_re,
    output busy
  );

  modport master (
    output spii_sck,
    output spii_mosi,
    output spii_spisel,
    output reg_rdata,
    input  spio_miso,
    input  spio_misooen,
    input  reg_addr,
    input  reg_we,
    input  reg_wdata,
    input  reg_re,
    input  busy
  );

endinterface

// File: rtl/spi_target_sync.sv
// Two-flop synchronizer for one asynchronous pin, with optional
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_target_sync #(
  parameter bit RST_VAL = 1'b0,
  parameter bit EDGES   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;

  // Two-stage capture of the asynchronous input; reset loads the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

  if (EDGES) begin : g_edge
    logic prev;

    // Delayed copy of the synchronized level for edge detection.
    always_ff @(posedge clk) begin
      if (rst) prev <= RST_VAL;
      else     prev <= sync;
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_target_regs.sv
// SPI mode-0 target bridging to a simple byte-wide register bus.
// Command byte: bit 7 = read, bits 6:0 = start address; following bytes
// are write data or dummy bytes clocking out read data, with the address
// auto-incrementing per byte.
module spi_target_regs #(
  parameter int ADDR_W      = 7,
  parameter int SCK_DIV_MIN = 8
) (
  input logic             clk,
  input logic             rst,
  spi_target_regs_if.slave bus
);
  import spi_target_pkg::*;

  // SCK must be no faster than clk/SCK_DIV_MIN; informational only.
  localparam int SCK_DIV_MIN_UNUSED = SCK_DIV_MIN;

  logic sck_rise, sck_fall, sck_unused_lvl;
  logic sel_n, sel_unused_rise, sel_unused_fall;
  logic mosi_s, mosi_unused_rise, mosi_unused_fall;

  spi_target_sync #(.RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .d   (bus.spii_sck),
    .q   (sck_unused_lvl),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  spi_target_sync #(.RST_VAL(1'b1), .EDGES(1'b1)) u_sync_sel (
    .clk (clk),
    .rst (rst),
    .d   (bus.spii_spisel),
    .q   (sel_n),
    .rise(sel_unused_rise),
    .fall(sel_unused_fall)
  );

  spi_target_sync #(.RST_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .d   (bus.spii_mosi),
    .q   (mosi_s),
    .rise(mosi_unused_rise),
    .fall(mosi_unused_fall)
  );

  state_t               state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BYTE_W-1:0]    rx_shift;
  logic [BYTE_W-1:0]    tx_shift;
  logic [BYTE_W-1:0]    rx_byte;
  logic [ADDR_W-1:0]    addr_q;
  logic [BYTE_W-1:0]    wdata_q;
  logic                 we_q, re_q;
  logic                 load_pend, inc_pend;
  logic [1:0]           settle_cnt;
  logic                 armed;
  logic                 active, byte_done;
  logic                 we_set, re_set, addr_load, addr_step;
  logic                 rd_drive;

  assign active    = (state != IDLE);
  assign rx_byte   = {rx_shift[BYTE_W-2:0], mosi_s};
  assign byte_done = active && sck_rise && (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

  // The select synchronizer holds its reset value for two cycles after
  // reset; only once it reflects the pin may a high select arm the FSM,
  // so a frame cut by reset is not resumed mid-byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'd2) settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd2 && sel_n) armed <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-byte strobe requests. A byte completing in the same
  // cycle as deselect still raises its strobe before returning to IDLE.
  always_comb begin
    state_nxt = state;
    we_set    = 1'b0;
    re_set    = 1'b0;
    addr_load = 1'b0;
    addr_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !sel_n) state_nxt = CMD;
      end
      CMD: begin
        if (byte_done) begin
          addr_load = 1'b1;
          if (rx_byte[CMD_RW_BIT]) begin
            state_nxt = RD_DATA;
            re_set    = 1'b1;
          end else begin
            state_nxt = WR_DATA;
          end
        end
      end
      WR_DATA: begin
        if (byte_done) we_set = 1'b1;
      end
      RD_DATA: begin
        if (byte_done) begin
          re_set    = 1'b1;
          addr_step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (active && sel_n) state_nxt = IDLE;
  end

  // Register-bus strobes, write data and address. Writes step the address
  // one cycle after reg_we so the strobe carries the address written;
  // reads step together with reg_re so the new address is the one fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      load_pend <= 1'b0;
      inc_pend  <= 1'b0;
      wdata_q   <= '0;
      addr_q    <= '0;
    end else begin
      we_q      <= we_set;
      re_q      <= re_set;
      load_pend <= re_set;
      inc_pend  <= we_set;
      if (we_set) wdata_q <= rx_byte;
      if (addr_load)                  addr_q <= ADDR_W'(rx_byte[CMD_RW_BIT-1:0]);
      else if (addr_step || inc_pend) addr_q <= addr_q + ADDR_W'(1);
    end
  end

  // Receive shifter and bit counter; cleared whenever the frame is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (state == IDLE || state_nxt == IDLE) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (sck_rise) begin
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
      rx_shift <= rx_byte;
    end
  end

  // Transmit shifter: loaded the cycle after reg_re, shifted on SCK falls
  // inside a byte. The fall following the 8th rise is skipped (bit_cnt = 0)
  // so the freshly loaded MSB stays on MISO for the next byte's first rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (state == IDLE || state_nxt == IDLE) begin
      tx_shift <= '0;
    end else if (state == RD_DATA && load_pend) begin
      tx_shift <= bus.reg_rdata;
    end else if (state == RD_DATA && sck_fall && bit_cnt != '0) begin
      tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
    end
  end

  assign rd_drive         = (state == RD_DATA) && !sel_n;
  assign bus.spio_misooen = ~rd_drive;
  assign bus.spio_miso    = rd_drive & tx_shift[BYTE_W-1];
  assign bus.reg_addr     = addr_q;
  assign bus.reg_we       = we_q;
  assign bus.reg_wdata    = wdata_q;
  assign bus.reg_re       = re_q;
  assign bus.busy         = ~sel_n;

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: SPI mode-0 controller at clk/8 and a
// fixed-content register file model answering reads one cycle after reg_re.
module tb_spi_target_regs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_target_regs_if #(.ADDR_W(7)) bus ();

  spi_target_regs #(.ADDR_W(7), .SCK_DIV_MIN(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic [7:0] rd_addr_q[$];

  function automatic logic [7:0] rd_model(input logic [6:0] a);
    case (a)
      7'h10:   return 8'h11;
      7'h11:   return 8'h22;
      default: return {1'b0, a} ^ 8'hC3;
    endcase
  endfunction

  // Register-file side: log strobes, return read data.
  always @(negedge clk) begin
    if (bus.reg_we) begin
      wr_addr_q.push_back(8'(bus.reg_addr));
      wr_data_q.push_back(bus.reg_wdata);
    end
    if (bus.reg_re) begin
      rd_addr_q.push_back(8'(bus.reg_addr));
      bus.reg_rdata = rd_model(bus.reg_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bit(input logic mo, output logic mi, output logic oe);
    bus.spii_mosi = mo;
    repeat (4) @(negedge clk);
    mi = bus.spio_miso;
    oe = bus.spio_misooen;
    bus.spii_sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.spii_sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi, output logic [7:0] oe);
    logic b, o;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(mo[i], b, o);
      mi[i] = b;
      oe[i] = o;
    end
  endtask

  task automatic sel_low();
    bus.spii_spisel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic sel_high();
    repeat (4) @(negedge clk);
    bus.spii_spisel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_we"},    32'(bus.reg_we),       32'd0);
    check({pfx, "_re"},    32'(bus.reg_re),       32'd0);
    check({pfx, "_addr"},  32'(bus.reg_addr),     32'd0);
    check({pfx, "_wdata"}, 32'(bus.reg_wdata),    32'd0);
    check({pfx, "_miso"},  32'(bus.spio_miso),    32'd0);
    check({pfx, "_oen"},   32'(bus.spio_misooen), 32'd1);
    check({pfx, "_busy"},  32'(bus.busy),         32'd0);
  endtask

  initial begin
    logic [7:0] mi, oe, d;
    logic       b, o;
    int         wb, rb;

    bus.spii_sck    = 1'b0;
    bus.spii_mosi   = 1'b0;
    bus.spii_spisel = 1'b1;

    // Reset values
    repeat (4) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Write frame 0x05, 0xA5, 0x3C with reg_we latency on the last bit
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    sel_low();
    check("wr_busy", 32'(bus.busy), 32'd1);
    xfer_byte(8'h05, mi, oe);
    d = 8'hA5;
    for (int i = 7; i >= 1; i--) xfer_bit(d[i], b, o);
    bus.spii_mosi = d[0];
    repeat (4) @(negedge clk);
    bus.spii_sck = 1'b1;
    @(negedge clk); check("lat_c1_we", 32'(bus.reg_we), 32'd0);
    @(negedge clk); check("lat_c2_we", 32'(bus.reg_we), 32'd0);
    @(negedge clk); check("lat_c3_we", 32'(bus.reg_we), 32'd1);
    check("lat_c3_addr",  32'(bus.reg_addr),  32'h05);
    check("lat_c3_wdata", 32'(bus.reg_wdata), 32'hA5);
    @(negedge clk); check("lat_c4_we", 32'(bus.reg_we), 32'd0);
    check("lat_c4_addr", 32'(bus.reg_addr), 32'h06);
    bus.spii_sck = 1'b0;
    xfer_byte(8'h3C, mi, oe);
    sel_high();
    check("wr_count", 32'(wr_addr_q.size() - wb), 32'd2);
    if (wr_addr_q.size() - wb == 2) begin
      check("wr0_addr", 32'(wr_addr_q[wb]),   32'h05);
      check("wr0_data", 32'(wr_data_q[wb]),   32'hA5);
      check("wr1_addr", 32'(wr_addr_q[wb+1]), 32'h06);
      check("wr1_data", 32'(wr_data_q[wb+1]), 32'h3C);
    end
    check("wr_no_re", 32'(rd_addr_q.size() - rb), 32'd0);

    // Read frame 0x90 + two dummy bytes
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    sel_low();
    xfer_byte(8'h90, mi, oe);
    check("rd_cmd_oen", 32'(oe), 32'hFF);
    xfer_byte(8'h00, mi, oe);
    check("rd_b0_miso", 32'(mi), 32'h11);
    check("rd_b0_oen",  32'(oe), 32'h00);
    xfer_byte(8'h00, mi, oe);
    check("rd_b1_miso", 32'(mi), 32'h22);
    check("rd_b1_oen",  32'(oe), 32'h00);
    sel_high();
    check("rd_end_oen",  32'(bus.spio_misooen), 32'd1);
    check("rd_end_miso", 32'(bus.spio_miso),    32'd0);
    check("rd_re_count", 32'(rd_addr_q.size() - rb), 32'd3);
    if (rd_addr_q.size() - rb == 3) begin
      check("rd_re0_addr", 32'(rd_addr_q[rb]),   32'h10);
      check("rd_re1_addr", 32'(rd_addr_q[rb+1]), 32'h11);
      check("rd_re2_addr", 32'(rd_addr_q[rb+2]), 32'h12);
    end
    check("rd_no_we", 32'(wr_addr_q.size() - wb), 32'd0);

    // Write at 0x7F wraps to 0x00
    wb = wr_addr_q.size();
    sel_low();
    xfer_byte(8'h7F, mi, oe);
    xfer_byte(8'h12, mi, oe);
    xfer_byte(8'h34, mi, oe);
    sel_high();
    check("wrap_count", 32'(wr_addr_q.size() - wb), 32'd2);
    if (wr_addr_q.size() - wb == 2) begin
      check("wrap0_addr", 32'(wr_addr_q[wb]),   32'h7F);
      check("wrap1_addr", 32'(wr_addr_q[wb+1]), 32'h00);
      check("wrap1_data", 32'(wr_data_q[wb+1]), 32'h34);
    end

    // Deselect after 5 bits of the first data byte
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    sel_low();
    xfer_byte(8'h20, mi, oe);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, b, o);
    bus.spii_spisel = 1'b1;
    repeat (10) @(negedge clk);
    check("part_no_we", 32'(wr_addr_q.size() - wb), 32'd0);
    check("part_busy",  32'(bus.busy),         32'd0);
    check("part_oen",   32'(bus.spio_misooen), 32'd1);
    sel_low();
    xfer_byte(8'h21, mi, oe);
    xfer_byte(8'h5A, mi, oe);
    sel_high();
    check("part_next_count", 32'(wr_addr_q.size() - wb), 32'd1);
    if (wr_addr_q.size() - wb == 1) begin
      check("part_next_addr", 32'(wr_addr_q[wb]), 32'h21);
      check("part_next_data", 32'(wr_data_q[wb]), 32'h5A);
    end
    check("part_no_re", 32'(rd_addr_q.size() - rb), 32'd0);

    // Reset during the 3rd bit of a read data byte
    sel_low();
    xfer_byte(8'h90, mi, oe);
    xfer_bit(1'b0, b, o);
    xfer_bit(1'b0, b, o);
    bus.spii_mosi = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    @(negedge clk);
    check_reset_outputs("mid_rst");
    repeat (2) @(negedge clk);
    bus.spii_sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.spii_sck = 1'b0;
    rst = 1'b0;
    xfer_byte(8'h80, mi, oe);
    check("post_rst_oen", 32'(oe), 32'hFF);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, b, o);
    sel_high();
    check("post_rst_no_we", 32'(wr_addr_q.size() - wb), 32'd0);
    check("post_rst_no_re", 32'(rd_addr_q.size() - rb), 32'd0);
    sel_low();
    xfer_byte(8'h30, mi, oe);
    xfer_byte(8'h77, mi, oe);
    sel_high();
    check("post_rst_wr_count", 32'(wr_addr_q.size() - wb), 32'd1);
    if (wr_addr_q.size() - wb == 1) begin
      check("post_rst_wr_addr", 32'(wr_addr_q[wb]), 32'h30);
      check("post_rst_wr_data", 32'(wr_data_q[wb]), 32'h77);
    end

    // SCK toggling with select high
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    for (int i = 0; i < 16; i++) begin
      bus.spii_mosi = i[0] ^ i[2];
      bus.spii_sck  = ~bus.spii_sck;
      repeat (4) @(negedge clk);
      if (i == 8) begin
        check("nosel_mid_busy", 32'(bus.busy),         32'd0);
        check("nosel_mid_oen",  32'(bus.spio_misooen), 32'd1);
      end
    end
    repeat (6) @(negedge clk);
    check("nosel_no_we", 32'(wr_addr_q.size() - wb), 32'd0);
    check("nosel_no_re", 32'(rd_addr_q.size() - rb), 32'd0);
    check("nosel_busy",  32'(bus.busy),         32'd0);
    check("nosel_oen",   32'(bus.spio_misooen), 32'd1);
    check("nosel_miso",  32'(bus.spio_miso),    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
